// File: rtl/iq_formatter.sv
// Byte-stream formatter for IQ data records and sync-counter records.
// Captures one record into shadow registers and streams it out with a valid/ready handshake.
module iq_formatter #(
  parameter int N_CH       = 4,
  parameter int DATA_BYTES = 7,
  parameter int TS_BYTES   = 5,
  parameter int SYNC_BYTES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid,
  input  logic                           valid_sync,
  input  logic [2*N_CH*8*DATA_BYTES-1:0] iq_data,
  input  logic [8*TS_BYTES-1:0]          ts,
  input  logic [8*SYNC_BYTES-1:0]        sync_cnt,
  output logic                           fmt_busy,
  output logic [7:0]                     dout,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic                           drop
);

  localparam int N_WORDS  = 2 * N_CH;
  localparam int IQ_BYTES = N_WORDS * DATA_BYTES;
  localparam int MAX_B0   = (DATA_BYTES > TS_BYTES) ? DATA_BYTES : TS_BYTES;
  localparam int MAX_B    = (MAX_B0 > SYNC_BYTES) ? MAX_B0 : SYNC_BYTES;
  localparam int BW       = (MAX_B > 1) ? $clog2(MAX_B) : 1;
  localparam int WW       = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int IQ_IW    = (IQ_BYTES > 1) ? $clog2(IQ_BYTES) : 1;
  localparam int TS_IW    = (TS_BYTES > 1) ? $clog2(TS_BYTES) : 1;
  localparam int SY_IW    = (SYNC_BYTES > 1) ? $clog2(SYNC_BYTES) : 1;

  localparam logic [7:0] HDR_DATA = 8'hFF;
  localparam logic [7:0] HDR_SYNC = 8'hF5;
  localparam logic [7:0] FOOTER   = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_TS,
    S_PAY,
    S_FOOT
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     byte_q, byte_d;
  logic [WW-1:0]     word_q, word_d;
  logic              is_sync_q, is_sync_d;
  logic              drop_q, drop_d;

  logic [IQ_BYTES-1:0][7:0]   iq_q;
  logic [TS_BYTES-1:0][7:0]   ts_q;
  logic [SYNC_BYTES-1:0][7:0] sync_q;

  logic idle;
  logic xfer;
  logic capture;

  // Byte index 0 is the most significant byte of each field.
  function automatic logic [7:0] pick_iq(input logic [IQ_BYTES-1:0][7:0] v,
                                         input logic [WW-1:0] w,
                                         input logic [BW-1:0] b);
    logic [IQ_IW-1:0] sel;
    sel = IQ_IW'(IQ_BYTES - 1) - (IQ_IW'(w) * IQ_IW'(DATA_BYTES) + IQ_IW'(b));
    return v[sel];
  endfunction

  function automatic logic [7:0] pick_ts(input logic [TS_BYTES-1:0][7:0] v,
                                         input logic [BW-1:0] b);
    logic [TS_IW-1:0] sel;
    sel = TS_IW'(TS_BYTES - 1) - TS_IW'(b);
    return v[sel];
  endfunction

  function automatic logic [7:0] pick_sync(input logic [SYNC_BYTES-1:0][7:0] v,
                                           input logic [BW-1:0] b);
    logic [SY_IW-1:0] sel;
    sel = SY_IW'(SYNC_BYTES - 1) - SY_IW'(b);
    return v[sel];
  endfunction

  assign idle       = (state_q == S_IDLE);
  assign xfer       = dout_valid & dout_ready;
  assign capture    = idle & (valid | valid_sync);
  assign fmt_busy   = ~idle;
  assign dout_valid = ~idle;
  assign drop       = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      byte_q    <= '0;
      word_q    <= '0;
      is_sync_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      word_q    <= word_d;
      is_sync_q <= is_sync_d;
      drop_q    <= drop_d;
    end
  end

  // Shadow registers hold the record in flight; they need no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      ts_q <= ts;
      if (valid) begin
        iq_q <= iq_data;
      end else begin
        sync_q <= sync_cnt;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    word_d    = word_q;
    is_sync_d = is_sync_q;
    drop_d    = idle ? (valid & valid_sync) : (valid | valid_sync);
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          state_d   = S_HEAD;
          is_sync_d = ~valid;
          byte_d    = '0;
          word_d    = '0;
        end
      end
      S_HEAD: begin
        if (xfer) begin
          state_d = S_TS;
        end
      end
      S_TS: begin
        if (xfer) begin
          if (byte_q == BW'(TS_BYTES - 1)) begin
            byte_d  = '0;
            state_d = S_PAY;
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      S_PAY: begin
        if (xfer) begin
          if (is_sync_q) begin
            if (byte_q == BW'(SYNC_BYTES - 1)) begin
              byte_d  = '0;
              state_d = S_FOOT;
            end else begin
              byte_d = byte_q + 1'b1;
            end
          end else if (byte_q == BW'(DATA_BYTES - 1)) begin
            byte_d = '0;
            if (word_q == WW'(N_WORDS - 1)) begin
              word_d  = '0;
              state_d = S_FOOT;
            end else begin
              word_d = word_q + 1'b1;
            end
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      S_FOOT: begin
        if (xfer) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    dout = 8'h00;
    case (state_q)
      S_HEAD:  dout = is_sync_q ? HDR_SYNC : HDR_DATA;
      S_TS:    dout = pick_ts(ts_q, byte_q);
      S_PAY:   dout = is_sync_q ? pick_sync(sync_q, byte_q) : pick_iq(iq_q, word_q, byte_q);
      S_FOOT:  dout = FOOTER;
      default: dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_iq_formatter.sv
// Bench for iq_formatter: table-driven records, collision/overlap/reset sequences,
// a synchronizer-style arbiter and randomized records against a byte-queue model.
module tb_iq_formatter;

  localparam int NCH = 4;
  localparam int DB  = 7;
  localparam int TSB = 5;
  localparam int SYB = 4;
  localparam int IQB = 2 * NCH * DB;
  localparam int IQW = 8 * IQB;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid, valid_sync;
  logic [IQW-1:0] iq_data;
  logic [8*TSB-1:0] ts;
  logic [8*SYB-1:0] sync_cnt;
  logic           fmt_busy;
  logic [7:0]     dout;
  logic           dout_valid;
  logic           dout_ready;
  logic           drop;

  iq_formatter #(.N_CH(NCH), .DATA_BYTES(DB), .TS_BYTES(TSB), .SYNC_BYTES(SYB)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .valid_sync (valid_sync),
    .iq_data    (iq_data),
    .ts         (ts),
    .sync_cnt   (sync_cnt),
    .fmt_busy   (fmt_busy),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               is_sync;
    logic [8*TSB-1:0] ts;
    logic [IQW-1:0]   iq;
    logic [8*SYB-1:0] sc;
    bit               bp;
    int               exp_len;
    logic [7:0]       exp_hdr;
  } vec_t;

  int         passed = 0;
  int         total  = 0;
  int         cyc    = 0;
  int         busy_cnt, drop_cnt, last_xfer_cyc;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_dout  = 8'h00;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passed++;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", 64'({dout_valid, dout}), 64'({1'b1, prev_dout}));
      if (fmt_busy) busy_cnt++;
      if (drop) drop_cnt++;
      if (dout_valid && dout_ready) begin
        got_q.push_back(dout);
        last_xfer_cyc = cyc;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
    end
  end

  // Reference model: a record is simply the header, the fields MSB byte first, then the footer.
  task automatic add_rec(input bit s, input logic [8*TSB-1:0] t, input logic [IQW-1:0] d,
                         input logic [8*SYB-1:0] c);
    exp_q.push_back(s ? 8'hF5 : 8'hFF);
    for (int i = TSB - 1; i >= 0; i--) exp_q.push_back(t[8*i +: 8]);
    if (s) for (int i = SYB - 1; i >= 0; i--) exp_q.push_back(c[8*i +: 8]);
    else   for (int i = IQB - 1; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
    exp_q.push_back(8'hEE);
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    busy_cnt = 0;
    drop_cnt = 0;
    last_xfer_cyc = -10;
  endtask

  task automatic compare_stream(input string name);
    int bad;
    bad = 0;
    check({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    check({name, "_bytes"}, 64'(bad), 64'd0);
  endtask

  // I0 = 0x11.., Q0 = 0x22.., ..., Q3 = 0x88..
  function automatic logic [IQW-1:0] pat_iq();
    logic [IQW-1:0] r;
    r = '0;
    for (int w = 0; w < 2 * NCH; w++)
      for (int b = 0; b < DB; b++)
        r[IQW-1-8*(w*DB+b) -: 8] = 8'((w + 1) * 17);
    return r;
  endfunction

  task automatic pulse(input bit v, input bit vs, input logic [8*TSB-1:0] t,
                       input logic [IQW-1:0] d, input logic [8*SYB-1:0] c);
    @(posedge clk); #1;
    valid = v; valid_sync = vs; ts = t; iq_data = d; sync_cnt = c; dout_ready = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; valid_sync = 1'b0; ts = ~t; iq_data = ~d; sync_cnt = ~c;
  endtask

  task automatic wait_done(input bit bp, output int done_cyc);
    bit done;
    done = 1'b0;
    done_cyc = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!fmt_busy) begin
        done = 1'b1;
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      if (bp) dout_ready = 1'($urandom_range(0, 1));
    end
    if (!done) check("record_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    dout_ready = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int dc;
    clear_obs();
    add_rec(v.is_sync, v.ts, v.iq, v.sc);
    pulse(!v.is_sync, v.is_sync, v.ts, v.iq, v.sc);
    @(negedge clk);
    check({tag, "_first_busy"}, 64'(fmt_busy), 64'd1);
    check({tag, "_first_valid"}, 64'(dout_valid), 64'd1);
    check({tag, "_first_hdr"}, 64'(dout), 64'(v.exp_hdr));
    wait_done(v.bp, dc);
    if (!v.bp) check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(v.exp_len));
    check({tag, "_busy_fall"}, 64'(dc), 64'(last_xfer_cyc + 1));
    check({tag, "_len_tbl"}, 64'(got_q.size()), 64'(v.exp_len));
    compare_stream(tag);
    check({tag, "_no_drop"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    vec_t rv;
    int   dc;
    bit   pend_d, pend_s, b2b_done;
    logic [31:0] tmp;

    tbl[0] = '{is_sync: 1'b0, ts: 40'h0102030405, iq: pat_iq(), sc: 32'h0, bp: 1'b0,
               exp_len: 63, exp_hdr: 8'hFF};
    tbl[1] = '{is_sync: 1'b1, ts: 40'h0A0B0C0D0E, iq: '0, sc: 32'hDEADBEEF, bp: 1'b0,
               exp_len: 11, exp_hdr: 8'hF5};
    tbl[2] = '{is_sync: 1'b0, ts: 40'h0102030405, iq: pat_iq(), sc: 32'h0, bp: 1'b1,
               exp_len: 63, exp_hdr: 8'hFF};
    tbl[3] = '{is_sync: 1'b1, ts: 40'h0, iq: '0, sc: 32'hFFFFFFFF, bp: 1'b1,
               exp_len: 11, exp_hdr: 8'hF5};

    rst = 1'b1; valid = 1'b0; valid_sync = 1'b0; iq_data = '0; ts = '0; sync_cnt = '0;
    dout_ready = 1'b1;
    clear_obs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(fmt_busy), 64'd0);
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Simultaneous strobes: data wins, one drop pulse.
    clear_obs();
    add_rec(1'b0, 40'h1122334455, pat_iq(), 32'h0);
    pulse(1'b1, 1'b1, 40'h1122334455, pat_iq(), 32'hCAFEF00D);
    wait_done(1'b0, dc);
    compare_stream("collide");
    check("collide_drop", 64'(drop_cnt), 64'd1);

    // Strobe during a record: stream unaffected, drop one cycle later.
    clear_obs();
    add_rec(1'b0, 40'hA1A2A3A4A5, pat_iq(), 32'h0);
    pulse(1'b1, 1'b0, 40'hA1A2A3A4A5, pat_iq(), 32'h0);
    repeat (4) @(posedge clk);
    #1;
    valid = 1'b1; iq_data = ~pat_iq(); ts = 40'h5555555555;
    @(negedge clk);
    check("ovl_drop_early", 64'(drop), 64'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    check("ovl_drop_pulse", 64'(drop), 64'd1);
    wait_done(1'b0, dc);
    compare_stream("overlap");
    check("ovl_drop_cnt", 64'(drop_cnt), 64'd1);

    // Reset while in the payload of a data record.
    clear_obs();
    pulse(1'b1, 1'b0, 40'h0102030405, pat_iq(), 32'h0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(dout_valid), 64'd0);
    check("midrst_busy", 64'(fmt_busy), 64'd0);
    run_vec(tbl[0], "after_rst");

    // Synchronizer-style arbitration: data then sync, strobing whenever the formatter is free.
    clear_obs();
    add_rec(1'b0, 40'h0000000100, pat_iq(), 32'h0);
    add_rec(1'b1, 40'h0000000200, '0, 32'h12345678);
    pend_d = 1'b1; pend_s = 1'b1; b2b_done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      valid = 1'b0; valid_sync = 1'b0;
      if (!fmt_busy) begin
        if (pend_d) begin
          valid = 1'b1; ts = 40'h0000000100; iq_data = pat_iq(); pend_d = 1'b0;
        end else if (pend_s) begin
          valid_sync = 1'b1; ts = 40'h0000000200; sync_cnt = 32'h12345678; pend_s = 1'b0;
        end else begin
          b2b_done = 1'b1;
          break;
        end
      end
    end
    check("b2b_finished", 64'(b2b_done), 64'd1);
    compare_stream("b2b");
    check("b2b_no_drop", 64'(drop_cnt), 64'd0);

    // Randomized records against the model.
    for (int r = 0; r < 10; r++) begin
      rv.is_sync = 1'($urandom_range(0, 1));
      tmp = $urandom();
      rv.ts = {tmp[7:0], $urandom()};
      for (int k = 0; k < IQB / 4; k++) rv.iq[32*k +: 32] = $urandom();
      rv.sc = $urandom();
      rv.bp = 1'($urandom_range(0, 1));
      rv.exp_len = rv.is_sync ? 2 + TSB + SYB : 2 + TSB + IQB;
      rv.exp_hdr = rv.is_sync ? 8'hF5 : 8'hFF;
      run_vec(rv, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
